// File: rtl/sram_queue_pkg.sv
// rtl/sram_queue_pkg.sv - shared parameters and types for the SRAM-backed queue
package sram_queue_pkg;
  localparam int DEPTH_DEF = 512;
  localparam int WIDTH_DEF = 51;
  localparam int AW_DEF    = $clog2(DEPTH_DEF);

  // Holds array entries plus one in-flight read plus two output-buffer slots.
  typedef logic [AW_DEF+1:0] count_t;
endpackage

// File: rtl/sram_queue_obuf.sv
// rtl/sram_queue_obuf.sv - two-entry registered output buffer feeding the consumer
module sram_queue_obuf
  import sram_queue_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             enq_valid_i,
  input  logic [WIDTH-1:0] enq_bits_i,
  output logic             enq_ready_o,
  output logic             deq_valid_o,
  input  logic             deq_ready_i,
  output logic [WIDTH-1:0] deq_bits_o,
  output logic [1:0]       ob_cnt_o,
  output logic [1:0]       ob_cnt_next_o
);
  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d, cnt_pop;
  logic             pop;

  always_comb begin
    pop     = deq_ready_i && (cnt_q != 2'd0);
    cnt_pop = cnt_q - {1'b0, pop};
    head_d  = pop ? tail_q : head_q;
    tail_d  = tail_q;
    // The caller only pushes when there is room after this cycle's pop.
    if (enq_valid_i) begin
      if (cnt_pop == 2'd0) head_d = enq_bits_i;
      else                 tail_d = enq_bits_i;
    end
    cnt_d = flush_i ? 2'd0 : cnt_pop + {1'b0, enq_valid_i};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  always_ff @(posedge clock) begin
    tail_q <= tail_d;
  end

  assign enq_ready_o   = (cnt_pop != 2'd2);
  assign deq_valid_o   = (cnt_q != 2'd0);
  assign deq_bits_o    = head_q;
  assign ob_cnt_o      = cnt_q;
  assign ob_cnt_next_o = cnt_d;
endmodule

// File: rtl/sram_queue_ctrl.sv
// rtl/sram_queue_ctrl.sv - FIFO controller over an external 1R1W array with read-ahead buffer
module sram_queue_ctrl
  import sram_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_bits,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_bits,
  input  logic             flush,
  output logic [AW+1:0]    count,
  output logic [AW-1:0]    R0_addr,
  output logic             R0_en,
  input  logic [WIDTH-1:0] R0_data,
  output logic [AW-1:0]    W0_addr,
  output logic             W0_en,
  output logic [WIDTH-1:0] W0_data
);
  logic [AW:0]      arr_cnt_q, arr_cnt_d;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic             inflight_q, inflight_d;
  logic             enq_fire, bypass, wr, rd, capture, ob_push, ob_room;
  logic [WIDTH-1:0] ob_push_bits;
  logic [1:0]       ob_cnt, ob_cnt_next;

  assign enq_ready = (arr_cnt_q != (AW+1)'(DEPTH));

  always_comb begin
    enq_fire     = enq_valid && enq_ready && !flush;
    bypass       = enq_fire && (arr_cnt_q == '0) && !inflight_q && ob_room;
    wr           = enq_fire && !bypass;
    capture      = inflight_q && !flush;
    ob_push      = bypass || capture;
    ob_push_bits = capture ? R0_data : enq_bits;
    // ob_cnt_next already counts this cycle's capture, so a new read fits iff it is < 2.
    rd           = !flush && (arr_cnt_q != '0) && (ob_cnt_next < 2'd2);
    inflight_d   = rd;
    wptr_d       = wr ? wptr_q + AW'(1) : wptr_q;
    rptr_d       = rd ? rptr_q + AW'(1) : rptr_q;
    arr_cnt_d    = arr_cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    if (flush) begin
      wptr_d    = '0;
      rptr_d    = '0;
      arr_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      arr_cnt_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      arr_cnt_q  <= arr_cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
    end
  end

  sram_queue_obuf #(.WIDTH(WIDTH)) u_obuf (
    .clock         (clock),
    .reset_n       (reset_n),
    .flush_i       (flush),
    .enq_valid_i   (ob_push),
    .enq_bits_i    (ob_push_bits),
    .enq_ready_o   (ob_room),
    .deq_valid_o   (deq_valid),
    .deq_ready_i   (deq_ready && !flush),
    .deq_bits_o    (deq_bits),
    .ob_cnt_o      (ob_cnt),
    .ob_cnt_next_o (ob_cnt_next)
  );

  assign count   = (AW+2)'(arr_cnt_q) + (AW+2)'(inflight_q) + (AW+2)'(ob_cnt);
  assign R0_en   = rd;
  assign R0_addr = rptr_q;
  assign W0_en   = wr;
  assign W0_addr = wptr_q;
  assign W0_data = enq_bits;
endmodule

// File: tb/tb_sram_queue_ctrl.sv
// tb/tb_sram_queue_ctrl.sv - scoreboard bench for sram_queue_ctrl
module tb_sram_queue_ctrl;
  import sram_queue_pkg::*;
  localparam int W = WIDTH_DEF;
  localparam int D = DEPTH_DEF;
  localparam int A = AW_DEF;

  logic         clock = 1'b0;
  logic         reset_n, enq_valid, enq_ready, deq_valid, deq_ready, flush;
  logic [W-1:0] enq_bits, deq_bits, R0_data, W0_data;
  logic [A+1:0] count;
  logic [A-1:0] R0_addr, W0_addr;
  logic         R0_en, W0_en;
  logic [W-1:0] mem [D];

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] sb [$];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (W0_en) mem[W0_addr] <= W0_data;
    if (R0_en) R0_data <= mem[R0_addr];
  end

  sram_queue_ctrl dut (
    .clock(clock), .reset_n(reset_n), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_bits(enq_bits), .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
    .flush(flush), .count(count), .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data)
  );

  // One clock: drive inputs, record handshakes into the scoreboard, advance to the next negedge.
  task automatic cycle(input logic ev, input logic [W-1:0] eb, input logic dr,
                       output logic dfire, output logic [W-1:0] exp_b, output logic [W-1:0] got_b);
    enq_valid = ev; enq_bits = eb; deq_ready = dr;
    #1;
    dfire = deq_valid && deq_ready && !flush;
    got_b = deq_bits;
    exp_b = 'x;
    if (enq_valid && enq_ready && !flush) sb.push_back(eb);
    if (dfire && sb.size() > 0) exp_b = sb.pop_front();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [W-1:0] rnd();
    return W'({$urandom(), $urandom()});
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0; enq_bits = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    #1;
    vectors++; if (enq_ready !== 1'b1) begin miscompares++; $display("FAIL reset_enq_ready got=%b want=1", enq_ready); end
    vectors++; if (deq_valid !== 1'b0) begin miscompares++; $display("FAIL reset_deq_valid got=%b want=0", deq_valid); end
    vectors++; if (deq_bits !== '0) begin miscompares++; $display("FAIL reset_deq_bits got=%h want=0", deq_bits); end
    vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset_count got=%0d want=0", count); end
    vectors++; if (R0_en !== 1'b0) begin miscompares++; $display("FAIL reset_r0_en got=%b want=0", R0_en); end
    vectors++; if (W0_en !== 1'b0) begin miscompares++; $display("FAIL reset_w0_en got=%b want=0", W0_en); end
    @(negedge clock);
  endtask

  task automatic drain(input string name, input int budget);
    logic df; logic [W-1:0] e, g;
    for (int i = 0; i < budget && sb.size() > 0; i++) begin
      cycle(1'b0, '0, 1'b1, df, e, g);
      if (df) begin
        vectors++;
        if (g !== e) begin miscompares++; $display("FAIL %s_data got=%h want=%h", name, g, e); end
      end
    end
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL %s_timeout left=%0d want=0", name, sb.size()); end
  endtask

  task automatic test_bypass();
    enq_valid = 1'b1; enq_bits = W'(1); deq_ready = 1'b0;
    #1;
    vectors++; if (W0_en !== 1'b0) begin miscompares++; $display("FAIL bypass_w0_en got=%b want=0", W0_en); end
    vectors++; if (R0_en !== 1'b0) begin miscompares++; $display("FAIL bypass_r0_en got=%b want=0", R0_en); end
    if (enq_ready) sb.push_back(W'(1));
    @(posedge clock); @(negedge clock);
    enq_valid = 1'b0;
    #1;
    vectors++; if (deq_valid !== 1'b1) begin miscompares++; $display("FAIL bypass_deq_valid got=%b want=1", deq_valid); end
    vectors++; if (deq_bits !== W'(1)) begin miscompares++; $display("FAIL bypass_deq_bits got=%h want=1", deq_bits); end
    vectors++; if (R0_en !== 1'b0) begin miscompares++; $display("FAIL bypass_r0_en_after got=%b want=0", R0_en); end
    @(negedge clock);
    drain("bypass", 10);
  endtask

  task automatic test_fill();
    logic df; logic [W-1:0] e, g;
    int bubbles = 0;
    for (int i = 0; i < D + 2; i++) cycle(1'b1, W'(i), 1'b0, df, e, g);
    vectors++; if (count !== (A+2)'(D + 2)) begin miscompares++; $display("FAIL fill_count got=%0d want=%0d", count, D + 2); end
    vectors++; if (enq_ready !== 1'b0) begin miscompares++; $display("FAIL fill_enq_ready got=%b want=0", enq_ready); end
    cycle(1'b1, W'(999), 1'b1, df, e, g);
    vectors++; if (!df || g !== W'(0)) begin miscompares++; $display("FAIL full_enq_deq got=%h want=0", g); end
    vectors++; if (count !== (A+2)'(D + 1)) begin miscompares++; $display("FAIL full_enq_deq_count got=%0d want=%0d", count, D + 1); end
    for (int i = 0; i < D + 20 && sb.size() > 0; i++) begin
      cycle(1'b0, '0, 1'b1, df, e, g);
      if (!df) bubbles++;
      else begin
        vectors++;
        if (g !== e) begin miscompares++; $display("FAIL fill_order got=%h want=%h", g, e); end
      end
    end
    vectors++; if (bubbles != 0 || sb.size() != 0) begin miscompares++; $display("FAIL fill_bubbles got=%0d left=%0d want=0", bubbles, sb.size()); end
    vectors++; if (count !== '0) begin miscompares++; $display("FAIL fill_empty_count got=%0d want=0", count); end
  endtask

  task automatic test_steady();
    logic df; logic [W-1:0] e, g;
    int bad_cnt = 0;
    for (int i = 0; i < 300; i++) cycle(1'b1, rnd(), 1'b0, df, e, g);
    vectors++; if (count !== (A+2)'(300)) begin miscompares++; $display("FAIL steady_fill_count got=%0d want=300", count); end
    for (int i = 0; i < 2000; i++) begin
      cycle(1'b1, rnd(), 1'b1, df, e, g);
      vectors++;
      if (!df || g !== e) begin miscompares++; $display("FAIL steady_data cyc=%0d got=%h want=%h", i, g, e); end
      if (count !== (A+2)'(300)) bad_cnt++;
    end
    vectors++; if (bad_cnt != 0) begin miscompares++; $display("FAIL steady_count cycles_off=%0d want=0", bad_cnt); end
    drain("steady", 400);
  endtask

  task automatic test_flush();
    logic df; logic [W-1:0] e, g;
    for (int i = 0; i < 5; i++) cycle(1'b1, rnd(), 1'b0, df, e, g);
    enq_valid = 1'b1; enq_bits = rnd(); deq_ready = 1'b1;
    #1;
    vectors++; if (R0_en !== 1'b1) begin miscompares++; $display("FAIL flush_setup_read got=%b want=1", R0_en); end
    #1;
    @(negedge clock);
    enq_valid = 1'b0; deq_ready = 1'b0; sb.delete();
    #1;
    vectors++; if (count !== (A+2)'(5)) begin miscompares++; $display("FAIL flush_pre_count got=%0d want=5", count); end
    flush = 1'b1; enq_valid = 1'b1; enq_bits = rnd(); deq_ready = 1'b1;
    #1;
    vectors++; if (R0_en !== 1'b0 || W0_en !== 1'b0) begin miscompares++; $display("FAIL flush_ports got=%b%b want=00", R0_en, W0_en); end
    @(negedge clock);
    flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    #1;
    vectors++; if (count !== '0) begin miscompares++; $display("FAIL flush_count got=%0d want=0", count); end
    vectors++; if (deq_valid !== 1'b0) begin miscompares++; $display("FAIL flush_deq_valid got=%b want=0", deq_valid); end
    @(negedge clock);
    cycle(1'b1, W'(12'hABC), 1'b0, df, e, g);
    cycle(1'b0, '0, 1'b1, df, e, g);
    vectors++; if (!df || g !== W'(12'hABC)) begin miscompares++; $display("FAIL flush_first got=%h want=abc", g); end
    vectors++; if (count !== '0) begin miscompares++; $display("FAIL flush_after_count got=%0d want=0", count); end
  endtask

  task automatic test_async_reset();
    logic df; logic [W-1:0] e, g;
    for (int i = 0; i < 10; i++) cycle(1'b1, rnd(), 1'b0, df, e, g);
    cycle(1'b1, rnd(), 1'b1, df, e, g);
    enq_valid = 1'b1; deq_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (enq_ready !== 1'b1) begin miscompares++; $display("FAIL areset_enq_ready got=%b want=1", enq_ready); end
    vectors++; if (deq_valid !== 1'b0) begin miscompares++; $display("FAIL areset_deq_valid got=%b want=0", deq_valid); end
    vectors++; if (deq_bits !== '0) begin miscompares++; $display("FAIL areset_deq_bits got=%h want=0", deq_bits); end
    vectors++; if (count !== '0) begin miscompares++; $display("FAIL areset_count got=%0d want=0", count); end
    vectors++; if (R0_en !== 1'b0 || W0_en !== 1'b0) begin miscompares++; $display("FAIL areset_ports got=%b%b want=00", R0_en, W0_en); end
    enq_valid = 1'b0; deq_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1; sb.delete();
    @(negedge clock);
    for (int i = 0; i < 4; i++) cycle(1'b1, rnd(), 1'b0, df, e, g);
    vectors++; if (count !== (A+2)'(4)) begin miscompares++; $display("FAIL areset_resume_count got=%0d want=4", count); end
    drain("areset", 20);
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_fill();
    test_steady();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
